// File: rtl/fft_frame_loader.sv
// Collects a serial stream of sign-magnitude complex samples into 8-sample frames
// and sequences the write/start/ready handshake of the downstream dit_fft_8.
module fft_frame_loader #(
    parameter int DW       = 16,
    parameter int NPT      = 8,
    parameter int BUSY_TMO = 16
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_data_r,
    input  logic [DW-1:0]     s_data_i,
    input  logic              s_last,
    output logic [NPT*DW-1:0] frame_r,
    output logic [NPT*DW-1:0] frame_i,
    output logic              fft_write,
    output logic              fft_start,
    input  logic              fft_ready,
    output logic [15:0]       frame_cnt,
    output logic              frame_err
);

    localparam int IW = $clog2(NPT);
    localparam int TW = $clog2(BUSY_TMO + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_START = 3'd2,
        ST_BUSY  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Sign-magnitude has two zeros; fold the negative one onto +0.
    function automatic logic [DW-1:0] norm_zero(input logic [DW-1:0] v);
        logic [DW-1:0] neg_zero;
        neg_zero = {1'b1, {(DW-1){1'b0}}};
        if (v == neg_zero) begin
            norm_zero = {DW{1'b0}};
        end else begin
            norm_zero = v;
        end
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [IW-1:0]       idx_r;
    logic                full_r;
    logic [NPT*DW-1:0]   buf_re_r;
    logic [NPT*DW-1:0]   buf_im_r;
    logic [NPT*DW-1:0]   frame_re_r;
    logic [NPT*DW-1:0]   frame_im_r;
    logic [TW-1:0]       tmo_r;
    logic [15:0]         frame_cnt_r;
    logic                frame_err_r;
    logic                fft_write_r;
    logic                fft_start_r;
    logic                write_nxt_s;
    logic                start_nxt_s;
    logic                s_ready_s;
    logic                accept_s;
    logic                last_slot_s;
    logic                transfer_s;

    assign s_ready_s   = !full_r && !RST;
    assign accept_s    = s_valid && s_ready_s;
    assign last_slot_s = (idx_r == IW'(NPT - 1));
    assign transfer_s  = (state_r == ST_IDLE) && full_r;

    // Collection buffer, fill index, full flag and framing-error pulse.
    always_ff @(posedge clk) begin
        if (RST) begin
            idx_r       <= {IW{1'b0}};
            full_r      <= 1'b0;
            buf_re_r    <= {(NPT*DW){1'b0}};
            buf_im_r    <= {(NPT*DW){1'b0}};
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            if (transfer_s) begin
                full_r <= 1'b0;
            end
            if (accept_s) begin
                buf_re_r[idx_r*DW +: DW] <= norm_zero(s_data_r);
                buf_im_r[idx_r*DW +: DW] <= norm_zero(s_data_i);
                if (last_slot_s) begin
                    // A missing s_last on the 8th sample is flagged but the frame is kept.
                    full_r      <= 1'b1;
                    idx_r       <= {IW{1'b0}};
                    frame_err_r <= !s_last;
                end else if (s_last) begin
                    idx_r       <= {IW{1'b0}};
                    frame_err_r <= 1'b1;
                end else begin
                    idx_r <= idx_r + IW'(1);
                end
            end
        end
    end

    // Control FSM state register.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Control FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (full_r) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: state_nxt_s = ST_START;
            ST_START: state_nxt_s = ST_BUSY;
            ST_BUSY: begin
                if (!fft_ready) begin
                    state_nxt_s = ST_DONE;
                end else if (tmo_r == TW'(BUSY_TMO - 1)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (fft_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Control FSM output decode, taken from the next state so the pulses can be registered.
    always_comb begin
        write_nxt_s = 1'b0;
        start_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_WRITE: write_nxt_s = 1'b1;
            ST_START: start_nxt_s = 1'b1;
            default: begin
                write_nxt_s = 1'b0;
                start_nxt_s = 1'b0;
            end
        endcase
    end

    // Output frame register, handshake pulses, frame counter and busy timeout.
    always_ff @(posedge clk) begin
        if (RST) begin
            frame_re_r  <= {(NPT*DW){1'b0}};
            frame_im_r  <= {(NPT*DW){1'b0}};
            fft_write_r <= 1'b0;
            fft_start_r <= 1'b0;
            frame_cnt_r <= 16'd0;
            tmo_r       <= {TW{1'b0}};
        end else begin
            fft_write_r <= write_nxt_s;
            fft_start_r <= start_nxt_s;
            if (transfer_s) begin
                frame_re_r <= buf_re_r;
                frame_im_r <= buf_im_r;
            end
            if (state_r == ST_START) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
                tmo_r       <= {TW{1'b0}};
            end else if ((state_r == ST_BUSY) && fft_ready) begin
                tmo_r <= tmo_r + TW'(1);
            end
        end
    end

    assign s_ready   = s_ready_s;
    assign frame_r   = frame_re_r;
    assign frame_i   = frame_im_r;
    assign fft_write = fft_write_r;
    assign fft_start = fft_start_r;
    assign frame_cnt = frame_cnt_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed self-checking bench for fft_frame_loader: framing, handshake timing,
// back-pressure, busy timeout, negative-zero normalisation and mid-frame reset.
module tb_fft_frame_loader;

    logic         clk = 1'b0;
    logic         RST;
    logic         s_valid;
    logic         s_ready;
    logic [15:0]  s_data_r;
    logic [15:0]  s_data_i;
    logic         s_last;
    logic [127:0] frame_r;
    logic [127:0] frame_i;
    logic         fft_write;
    logic         fft_start;
    logic         fft_ready;
    logic [15:0]  frame_cnt;
    logic         frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_write  = 0;
    int n_start  = 0;
    int n_err    = 0;
    int write_cyc = 0;
    int start_cyc = 0;
    int err_cyc   = 0;
    int acc_cyc   = 0;
    int exp_cnt   = 0;
    logic [127:0] cap_r = '0;
    logic [127:0] cap_i = '0;

    fft_frame_loader dut (
        .clk(clk), .RST(RST), .s_valid(s_valid), .s_ready(s_ready),
        .s_data_r(s_data_r), .s_data_i(s_data_i), .s_last(s_last),
        .frame_r(frame_r), .frame_i(frame_i), .fft_write(fft_write),
        .fft_start(fft_start), .fft_ready(fft_ready), .frame_cnt(frame_cnt),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (fft_write) begin
            n_write   <= n_write + 1;
            write_cyc <= cyc;
            cap_r     <= frame_r;
            cap_i     <= frame_i;
        end
        if (fft_start) begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
        end
        if (frame_err) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
        end
    end

    function automatic logic [127:0] pack8(input logic [15:0] v [8]);
        logic [127:0] p;
        for (int k = 0; k < 8; k++) p[16*k +: 16] = v[k];
        return p;
    endfunction

    task automatic send(input logic [15:0] r, input logic [15:0] i, input logic last);
        int k;
        s_valid = 1'b1; s_data_r = r; s_data_i = i; s_last = last;
        k = 0;
        @(negedge clk);
        while (!s_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_timeout s_ready=%b required=1", s_ready);
        end
        acc_cyc = cyc;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_writes(input int target, input int bound);
        for (int k = 0; k < bound && n_write < target; k++) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        fft_ready = 1'b1;
        repeat (24) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data_r = 16'h0; s_data_i = 16'h0;
        fft_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({s_ready, fft_write, fft_start, frame_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b required=0000", {s_ready, fft_write, fft_start, frame_err});
        end
        n_checks++;
        if ({frame_r, frame_i} !== 256'h0) begin
            n_fail++;
            $display("FAIL reset_frame got=%h/%h required=0", frame_r, frame_i);
        end
        n_checks++;
        if (frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt got=%0d required=0", frame_cnt);
        end
        @(posedge clk); #1;
        RST = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset got=%b required=1", s_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_frame();
        logic [15:0] v [8] = '{16'h0500, 16'h0600, 16'h0400, 16'h0400,
                               16'h0700, 16'h0600, 16'h0700, 16'h0900};
        int w0, e0, t8;
        w0 = n_write; e0 = n_err;
        for (int k = 0; k < 8; k++) send(v[k], 16'h0000, k == 7);
        t8 = acc_cyc;
        wait_writes(w0 + 1, 10);
        n_checks++;
        if (n_write !== w0 + 1) begin
            n_fail++;
            $display("FAIL t1_write_count got=%0d required=%0d", n_write, w0 + 1);
        end
        n_checks++;
        if (write_cyc !== t8 + 2) begin
            n_fail++;
            $display("FAIL t1_write_latency got=%0d required=%0d", write_cyc - t8, 2);
        end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (cap_r[16*k +: 16] !== v[k]) begin
                n_fail++;
                $display("FAIL t1_lane%0d_r got=%h required=%h", k, cap_r[16*k +: 16], v[k]);
            end
        end
        n_checks++;
        if (cap_i !== 128'h0) begin
            n_fail++;
            $display("FAIL t1_frame_i got=%h required=0", cap_i);
        end
        repeat (3) @(posedge clk); #1;
        exp_cnt = 1;
        n_checks++;
        if (start_cyc !== t8 + 3) begin
            n_fail++;
            $display("FAIL t1_start_latency got=%0d required=%0d", start_cyc - t8, 3);
        end
        n_checks++;
        if (frame_cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL t1_frame_cnt got=%0d required=%0d", frame_cnt, exp_cnt);
        end
        n_checks++;
        if (n_err !== e0) begin
            n_fail++;
            $display("FAIL t1_no_err got=%0d required=%0d", n_err, e0);
        end
        drain();
    endtask

    task automatic test_fft_stall();
        logic [15:0] va [8] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404,
                                16'h0505, 16'h0606, 16'h0707, 16'h0808};
        logic [15:0] vb [8] = '{16'h1001, 16'h1002, 16'h1003, 16'h1004,
                                16'h1005, 16'h1006, 16'h1007, 16'h1008};
        logic [15:0] ia [8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
                                16'h0004, 16'h0005, 16'h0006, 16'h0007};
        logic [15:0] ib [8] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103,
                                16'h0104, 16'h0105, 16'h0106, 16'h0107};
        int w0, rise;
        fft_ready = 1'b0;
        w0 = n_write;
        for (int k = 0; k < 8; k++) send(va[k], ia[k], k == 7);
        for (int k = 0; k < 8; k++) send(vb[k], ib[k], k == 7);
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL t2_backpressure got=%b required=0", s_ready);
        end
        n_checks++;
        if (n_write !== w0 + 1) begin
            n_fail++;
            $display("FAIL t2_stalled_writes got=%0d required=%0d", n_write - w0, 1);
        end
        repeat (12) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({frame_r, frame_i} !== {pack8(va), pack8(ia)}) begin
            n_fail++;
            $display("FAIL t2_frame_hold got=%h required=%h", frame_r, pack8(va));
        end
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL t2_backpressure_hold got=%b required=0", s_ready);
        end
        @(posedge clk); #1;
        rise = cyc;
        fft_ready = 1'b1;
        wait_writes(w0 + 2, 10);
        n_checks++;
        if (n_write !== w0 + 2 || write_cyc !== rise + 2) begin
            n_fail++;
            $display("FAIL t2_resume_write got=%0d writes at +%0d required=%0d at +2",
                     n_write - w0, write_cyc - rise, 2);
        end
        n_checks++;
        if ({cap_r, cap_i} !== {pack8(vb), pack8(ib)}) begin
            n_fail++;
            $display("FAIL t2_frame2 got=%h/%h required=%h/%h", cap_r, cap_i, pack8(vb), pack8(ib));
        end
        repeat (3) @(posedge clk); #1;
        exp_cnt = exp_cnt + 2;
        n_checks++;
        if (frame_cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL t2_frame_cnt got=%0d required=%0d", frame_cnt, exp_cnt);
        end
        drain();
    endtask

    task automatic test_short_frame();
        logic [15:0] v [8] = '{16'h0B00, 16'h0B01, 16'h0B02, 16'h0B03,
                               16'h0B04, 16'h0B05, 16'h0B06, 16'h0B07};
        int w0, e0, t5;
        w0 = n_write; e0 = n_err;
        for (int k = 0; k < 5; k++) send(16'h0A00 + 16'(k), 16'h0A00, k == 4);
        t5 = acc_cyc;
        repeat (6) @(posedge clk); #1;
        n_checks++;
        if (n_err !== e0 + 1 || err_cyc !== t5 + 1) begin
            n_fail++;
            $display("FAIL t3_short_err got=%0d pulses at +%0d required=1 at +1", n_err - e0, err_cyc - t5);
        end
        n_checks++;
        if (n_write !== w0) begin
            n_fail++;
            $display("FAIL t3_no_write got=%0d required=0", n_write - w0);
        end
        for (int k = 0; k < 8; k++) send(v[k], 16'h0000, k == 7);
        wait_writes(w0 + 1, 10);
        n_checks++;
        if (n_write !== w0 + 1 || cap_r !== pack8(v)) begin
            n_fail++;
            $display("FAIL t3_next_frame got=%h required=%h", cap_r, pack8(v));
        end
        n_checks++;
        if (n_err !== e0 + 1) begin
            n_fail++;
            $display("FAIL t3_err_count got=%0d required=1", n_err - e0);
        end
        exp_cnt = exp_cnt + 1;
        drain();
    endtask

    task automatic test_bad_last();
        logic [15:0] vr [8] = '{16'h0101, 16'h0202, 16'h0303, 16'h8000,
                                16'h0505, 16'h0606, 16'h0707, 16'h0808};
        logic [15:0] vi [8] = '{16'h0011, 16'h0022, 16'h8123, 16'h0044,
                                16'h0055, 16'h8000, 16'h0077, 16'h0088};
        logic [15:0] er [8] = '{16'h0101, 16'h0202, 16'h0303, 16'h0000,
                                16'h0505, 16'h0606, 16'h0707, 16'h0808};
        logic [15:0] ei [8] = '{16'h0011, 16'h0022, 16'h8123, 16'h0044,
                                16'h0055, 16'h0000, 16'h0077, 16'h0088};
        int w0, e0, t8;
        w0 = n_write; e0 = n_err;
        for (int k = 0; k < 8; k++) send(vr[k], vi[k], 1'b0);
        t8 = acc_cyc;
        wait_writes(w0 + 1, 10);
        n_checks++;
        if (n_err !== e0 + 1 || err_cyc !== t8 + 1) begin
            n_fail++;
            $display("FAIL t4_missing_last_err got=%0d pulses at +%0d required=1 at +1", n_err - e0, err_cyc - t8);
        end
        n_checks++;
        if (n_write !== w0 + 1 || write_cyc !== t8 + 2) begin
            n_fail++;
            $display("FAIL t4_write_issued got=%0d at +%0d required=1 at +2", n_write - w0, write_cyc - t8);
        end
        n_checks++;
        if (cap_r[63:48] !== 16'h0000) begin
            n_fail++;
            $display("FAIL t4_lane3_negzero got=%h required=0000", cap_r[63:48]);
        end
        n_checks++;
        if ({cap_r, cap_i} !== {pack8(er), pack8(ei)}) begin
            n_fail++;
            $display("FAIL t4_frame got=%h/%h required=%h/%h", cap_r, cap_i, pack8(er), pack8(ei));
        end
        exp_cnt = exp_cnt + 1;
        drain();
    endtask

    task automatic test_busy_timeout();
        logic [15:0] va [8] = '{16'h2000, 16'h2001, 16'h2002, 16'h2003,
                                16'h2004, 16'h2005, 16'h2006, 16'h2007};
        logic [15:0] vb [8] = '{16'h3000, 16'h3100, 16'h3200, 16'h3300,
                                16'h3400, 16'h3500, 16'h3600, 16'h3700};
        int w0, s0, a_start;
        fft_ready = 1'b1;
        w0 = n_write; s0 = n_start;
        for (int k = 0; k < 8; k++) send(va[k], 16'h0000, k == 7);
        for (int k = 0; k < 10 && n_start < s0 + 1; k++) @(posedge clk);
        #1;
        a_start = start_cyc;
        for (int k = 0; k < 8; k++) send(vb[k], 16'h0000, k == 7);
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_backpressure got=%b required=0", s_ready);
        end
        wait_writes(w0 + 2, 30);
        n_checks++;
        if (n_write !== w0 + 2 || write_cyc !== a_start + 18) begin
            n_fail++;
            $display("FAIL t5_timeout_spacing got=%0d writes, start-to-write %0d required=2, 18",
                     n_write - w0, write_cyc - a_start);
        end
        n_checks++;
        if (cap_r !== pack8(vb)) begin
            n_fail++;
            $display("FAIL t5_queued_frame got=%h required=%h", cap_r, pack8(vb));
        end
        repeat (3) @(posedge clk); #1;
        exp_cnt = exp_cnt + 2;
        n_checks++;
        if (frame_cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL t5_frame_cnt got=%0d required=%0d", frame_cnt, exp_cnt);
        end
        drain();
    endtask

    task automatic test_reset_midframe();
        logic [15:0] v [8] = '{16'h0C00, 16'h0C11, 16'h0C22, 16'h0C33,
                               16'h0C44, 16'h0C55, 16'h0C66, 16'h0C77};
        int w0;
        w0 = n_write;
        for (int k = 0; k < 4; k++) send(16'h0E00 + 16'(k), 16'h0E00, 1'b0);
        RST = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_ready_in_reset got=%b required=0", s_ready);
        end
        @(posedge clk); #1;
        RST = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({frame_r, frame_i} !== 256'h0 || frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL t6_reset_outputs got=%h cnt=%0d required=0 cnt=0", frame_r, frame_cnt);
        end
        n_checks++;
        if ({fft_write, fft_start, frame_err, s_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL t6_reset_ctrl got=%b required=0001", {fft_write, fft_start, frame_err, s_ready});
        end
        @(posedge clk); #1;
        exp_cnt = 0;
        for (int k = 0; k < 8; k++) send(v[k], 16'h0000, k == 7);
        wait_writes(w0 + 1, 10);
        n_checks++;
        if (cap_r !== pack8(v)) begin
            n_fail++;
            $display("FAIL t6_frame_after_reset got=%h required=%h", cap_r, pack8(v));
        end
        repeat (20) @(posedge clk); #1;
        exp_cnt = 1;
        n_checks++;
        if (n_write !== w0 + 1) begin
            n_fail++;
            $display("FAIL t6_write_count got=%0d required=1", n_write - w0);
        end
        n_checks++;
        if (frame_cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL t6_frame_cnt got=%0d required=%0d", frame_cnt, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_fft_stall();
        test_short_frame();
        test_bad_last();
        test_busy_timeout();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d required finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
